mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter sharing one synchronous memory port.
// Each access is IDLE -> ACCESS -> CAPTURE; the ack shows up in the following IDLE cycle.
module mem_port_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] addr1,
    input  logic [N-1:0] wdata0,
    input  logic [N-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         ack0,
    output logic         ack1,
    output logic [N-1:0] rdata0,
    output logic [N-1:0] rdata1,
    output logic         mem_wr_ena,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wr_data,
    input  logic [N-1:0] mem_rd_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         id_q, id_d;
    logic         we_q, we_d;
    logic         last_q, last_d;
    logic         gnt0_q, gnt0_d;
    logic         gnt1_q, gnt1_d;
    logic         ack0_q, ack0_d;
    logic         ack1_q, ack1_d;
    logic         mem_wr_ena_q, mem_wr_ena_d;
    logic [N-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0] mem_wr_data_q, mem_wr_data_d;
    logic [N-1:0] rdata0_q, rdata0_d;
    logic [N-1:0] rdata1_q, rdata1_d;

    logic any_req;
    logic win_id;

    // On a tie the requester that did not win last time goes next;
    // last_q resets to 1 so requester 0 is favoured first.
    assign any_req = req0 | req1;
    assign win_id  = (req0 && req1) ? ~last_q : req1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        id_d          = id_q;
        we_d          = we_q;
        last_d        = last_q;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        mem_wr_ena_d  = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    id_d          = win_id;
                    last_d        = win_id;
                    we_d          = win_id ? we1 : we0;
                    gnt0_d        = ~win_id;
                    gnt1_d        = win_id;
                    mem_wr_ena_d  = win_id ? we1 : we0;
                    mem_addr_d    = win_id ? addr1 : addr0;
                    mem_wr_data_d = win_id ? wdata1 : wdata0;
                end
            end
            CAPTURE: begin
                // Memory data for the address driven in ACCESS is valid now.
                ack0_d = ~id_q;
                ack1_d = id_q;
                if (!we_q) begin
                    if (id_q) rdata1_d = mem_rd_data;
                    else      rdata0_d = mem_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            id_q          <= 1'b0;
            we_q          <= 1'b0;
            last_q        <= 1'b1;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            mem_wr_ena_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            id_q          <= id_d;
            we_q          <= we_d;
            last_q        <= last_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            mem_wr_ena_q  <= mem_wr_ena_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_wr_ena  = mem_wr_ena_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single accesses plus
// hand-written contention, starvation, mid-access reset and late-change sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstb;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        mem_wr_ena;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic        mem_clear;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(32)) dut (
        .clk(clk), .rstb(rstb),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_wr_ena(mem_wr_ena), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .busy(busy)
    );

    // External synchronous memory: one-cycle registered read, low 8 address bits.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem_rd_data <= 32'h0;
        end else begin
            if (mem_wr_ena) mem[mem_addr[7:0]] <= mem_wr_data;
            mem_rd_data <= mem[mem_addr[7:0]];
        end
    end

    typedef struct packed {
        logic        r0;
        logic        w0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic        exp_id;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
    } vec_t;

    vec_t vecs [0:9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        logic        exp_we;
        logic [31:0] exp_a, exp_d;
        exp_we = v.exp_id ? v.w1 : v.w0;
        exp_a  = v.exp_id ? v.a1 : v.a0;
        exp_d  = v.exp_id ? v.d1 : v.d0;
        @(negedge clk);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        @(posedge clk); #1;
        chk($sformatf("txn%0d gnt0", idx), {31'b0, gnt0}, {31'b0, ~v.exp_id});
        chk($sformatf("txn%0d gnt1", idx), {31'b0, gnt1}, {31'b0, v.exp_id});
        chk($sformatf("txn%0d wr_ena", idx), {31'b0, mem_wr_ena}, {31'b0, exp_we});
        chk($sformatf("txn%0d mem_addr", idx), mem_addr, exp_a);
        chk($sformatf("txn%0d mem_wr_data", idx), mem_wr_data, exp_d);
        chk($sformatf("txn%0d ack_low", idx), {30'b0, ack1, ack0}, 32'h0);
        chk($sformatf("txn%0d busy_access", idx), {31'b0, busy}, 32'h1);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("txn%0d capture_wr_ena", idx), {31'b0, mem_wr_ena}, 32'h0);
        chk($sformatf("txn%0d capture_gnt", idx), {30'b0, gnt1, gnt0}, 32'h0);
        @(posedge clk); #1;
        chk($sformatf("txn%0d ack0", idx), {31'b0, ack0}, {31'b0, ~v.exp_id});
        chk($sformatf("txn%0d ack1", idx), {31'b0, ack1}, {31'b0, v.exp_id});
        chk($sformatf("txn%0d busy_idle", idx), {31'b0, busy}, 32'h0);
        chk($sformatf("txn%0d rdata0", idx), rdata0, v.exp_rd0);
        chk($sformatf("txn%0d rdata1", idx), rdata1, v.exp_rd1);
    endtask

    initial begin
        logic e_g0, e_g1, e_a0, e_a1, e_b;
        vec_t v;

        vecs[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0,
                    1'b1, 32'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678,
                    1'b1, 32'h0, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0,
                    1'b0, 32'h12345678, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h20, 32'h0,
                    1'b1, 32'h12345678, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D,
                    1'b0, 32'hDEADBEEF, 32'h12345678};
        vecs[6] = '{1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 32'hDEADBEEF, 32'h12345678};
        vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001,
                    1'b1, 32'hDEADBEEF, 32'h12345678};
        vecs[8] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,
                    1'b1, 32'hDEADBEEF, 32'h00000001};
        vecs[9] = '{1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 32'hA5A5A5A5, 32'h00000001};

        rstb = 1'b0; mem_clear = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        #2;
        chk("reset gnt", {30'b0, gnt1, gnt0}, 32'h0);
        chk("reset ack", {30'b0, ack1, ack0}, 32'h0);
        chk("reset wr_ena", {31'b0, mem_wr_ena}, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wr_data", mem_wr_data, 32'h0);
        chk("reset rdata0", rdata0, 32'h0);
        chk("reset rdata1", rdata1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clear = 1'b0;
        rstb = 1'b1;

        for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

        // Contention: both requesters held from reset, grants alternate every 3 cycles.
        #1 rstb = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
        @(negedge clk); rstb = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            e_g0 = (c % 6 == 0); e_g1 = (c % 6 == 3);
            e_a0 = (c % 6 == 2); e_a1 = (c % 6 == 5);
            e_b  = (c % 3 != 2);
            chk($sformatf("cont c%0d gnt0", c), {31'b0, gnt0}, {31'b0, e_g0});
            chk($sformatf("cont c%0d gnt1", c), {31'b0, gnt1}, {31'b0, e_g1});
            chk($sformatf("cont c%0d ack0", c), {31'b0, ack0}, {31'b0, e_a0});
            chk($sformatf("cont c%0d ack1", c), {31'b0, ack1}, {31'b0, e_a1});
            chk($sformatf("cont c%0d busy", c), {31'b0, busy}, {31'b0, e_b});
        end

        // Starvation: req0 held, req1 raised once during req0's access.
        #1 rstb = 1'b0;
        req0 = 1'b1; req1 = 1'b0;
        @(negedge clk); rstb = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            e_g0 = (c == 0 || c == 6); e_g1 = (c == 3);
            chk($sformatf("starve c%0d gnt0", c), {31'b0, gnt0}, {31'b0, e_g0});
            chk($sformatf("starve c%0d gnt1", c), {31'b0, gnt1}, {31'b0, e_g1});
            if (c == 0) req1 = 1'b1;
            if (c == 3) req1 = 1'b0;
        end
        req0 = 1'b0;
        repeat (2) @(posedge clk);

        // Reset asserted mid-write: write enable must drop without a clock edge.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h70; wdata0 = 32'h77777777;
        @(posedge clk); #1;
        chk("rstwr gnt0", {31'b0, gnt0}, 32'h1);
        chk("rstwr wr_ena_before", {31'b0, mem_wr_ena}, 32'h1);
        #2 rstb = 1'b0;
        #1;
        chk("rstwr wr_ena_async", {31'b0, mem_wr_ena}, 32'h0);
        chk("rstwr busy_async", {31'b0, busy}, 32'h0);
        chk("rstwr gnt_async", {30'b0, gnt1, gnt0}, 32'h0);
        chk("rstwr mem_addr_async", mem_addr, 32'h0);
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk); rstb = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rstwr c%0d ack", c), {30'b0, ack1, ack0}, 32'h0);
            chk($sformatf("rstwr c%0d busy", c), {31'b0, busy}, 32'h0);
        end
        v = '{1'b1, 1'b0, 32'h70, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
        run_txn(v, 100);

        // Late change: addr0/wdata0 altered during CAPTURE must not affect the access.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h50; wdata0 = 32'h11112222;
        @(posedge clk); #1;
        chk("late gnt0", {31'b0, gnt0}, 32'h1);
        chk("late mem_addr_access", mem_addr, 32'h50);
        req0 = 1'b0;
        @(posedge clk); #1;
        addr0 = 32'h60; wdata0 = 32'h99999999;
        #1;
        chk("late mem_addr_capture", mem_addr, 32'h50);
        chk("late mem_wr_data_capture", mem_wr_data, 32'h11112222);
        @(posedge clk); #1;
        chk("late ack0", {31'b0, ack0}, 32'h1);
        v = '{1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h11112222, 32'h0};
        run_txn(v, 101);
        v = '{1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
        run_txn(v, 102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
